// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: IF/ID bundle, nop encoding, reset PC
// and the fetch-stage FSM encoding.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc_4;
    logic [31:0] instruction;
    logic        valid;
  } if_id_t;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_next_select.sv
// Next-PC priority mux applied on a delivery: live branch, then a latched
// redirect, then sequential pc+4 (wraps modulo 2^32).
module pc_next_select
  import pipeline_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        redirect_pending,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc + 32'd4;
    if (br_take) begin
      next_pc = word_align(br_target);
    end else if (redirect_pending) begin
      next_pc = redirect_pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, one outstanding
// variable-latency fetch, single-delay-slot redirects and a 1-entry stall buffer.
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] jumpOrBranchPc,
  output logic        imemRequest,
  output logic [31:0] imemAddress,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] pc_4,
  output logic [31:0] instruction,
  output logic        instructionValid,
  output logic [31:0] debug_pc
);

  // Handshake: a fetch completes on a cycle where imemRequest=1 and
  // imemReady=1; imemAddress is stable while imemRequest is held high.
  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        redirect_pending_q, redirect_pending_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        hold_valid;
  logic        mem_fire;
  logic        br_take;
  logic        deliver;
  logic [31:0] src_instr;
  logic [31:0] next_pc;

  assign hold_valid  = (state_q == HOLD);
  assign imemRequest = reset & ~hold_valid;
  assign imemAddress = pc_q;
  assign mem_fire    = imemRequest & imemReady;
  assign br_take     = shouldJumpOrBranch & ifid_q.valid & ~shouldStall;
  assign deliver     = ~shouldStall & (hold_valid | mem_fire);
  // The PC is frozen while a word sits in the hold buffer, so pc_q is
  // always the address of whichever source is delivering.
  assign src_instr   = hold_valid ? hold_instr_q : imemData;

  pc_next_select u_pc_next_select (
    .pc               (pc_q),
    .br_take          (br_take),
    .br_target        (jumpOrBranchPc),
    .redirect_pending (redirect_pending_q),
    .redirect_pc      (redirect_pc_q),
    .next_pc          (next_pc)
  );

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    ifid_d             = ifid_q;
    hold_instr_d       = hold_instr_q;
    redirect_pending_d = redirect_pending_q;
    redirect_pc_d      = redirect_pc_q;
    if (deliver) begin
      ifid_d.pc_4        = pc_q + 32'd4;
      ifid_d.instruction = src_instr;
      ifid_d.valid       = 1'b1;
      pc_d               = next_pc;
      redirect_pending_d = 1'b0;
      state_d            = FETCH;
    end else if (!shouldStall) begin
      ifid_d.instruction = NOP_INSTRUCTION;
      ifid_d.valid       = 1'b0;
      // Delay slot still in flight: apply the redirect once it is delivered.
      if (br_take) begin
        redirect_pending_d = 1'b1;
        redirect_pc_d      = word_align(jumpOrBranchPc);
      end
    end else if (mem_fire) begin
      hold_instr_d = imemData;
      state_d      = HOLD;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q            <= FETCH;
      pc_q               <= RESET_PC;
      ifid_q             <= '0;
      hold_instr_q       <= NOP_INSTRUCTION;
      redirect_pending_q <= 1'b0;
      redirect_pc_q      <= '0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      ifid_q             <= ifid_d;
      hold_instr_q       <= hold_instr_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_pc_q      <= redirect_pc_d;
    end
  end

  assign pc_4             = ifid_q.pc_4;
  assign instruction      = ifid_q.instruction;
  assign instructionValid = ifid_q.valid;
  assign debug_pc         = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a memory model with programmable latency, and a
// scoreboard of expected fetch addresses and IF/ID deliveries.
module tb_if_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        shouldStall = 1'b0;
  logic        shouldJumpOrBranch = 1'b0;
  logic [31:0] jumpOrBranchPc = '0;
  logic        imemRequest;
  logic [31:0] imemAddress;
  logic        imemReady = 1'b0;
  logic [31:0] imemData = '0;
  logic [31:0] pc_4;
  logic [31:0] instruction;
  logic        instructionValid;
  logic [31:0] debug_pc;

  if_stage dut (
    .clock              (clock),
    .reset              (reset),
    .shouldStall        (shouldStall),
    .shouldJumpOrBranch (shouldJumpOrBranch),
    .jumpOrBranchPc     (jumpOrBranchPc),
    .imemRequest        (imemRequest),
    .imemAddress        (imemAddress),
    .imemReady          (imemReady),
    .imemData           (imemData),
    .pc_4               (pc_4),
    .instruction        (instruction),
    .instructionValid   (instructionValid),
    .debug_pc           (debug_pc)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int bubble_cnt = 0;
  logic [63:0] exp_q[$];       // {pc_4, instruction}
  logic [31:0] exp_addr_q[$];  // accepted fetch addresses

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic push_fetch(input logic [31:0] addr);
    exp_addr_q.push_back(addr);
  endtask

  task automatic push_del(input logic [31:0] exp_pc_4, input logic [31:0] addr);
    exp_q.push_back({exp_pc_4, word_at(addr)});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- memory model ----------------
  int mem_lat = 0;
  logic mem_pause = 1'b0;
  logic mem_force = 1'b0;
  int wait_cnt = 0;

  initial forever begin
    @(negedge clock);
    #1;
    if (mem_force) begin
      imemReady = 1'b1;
    end else if (!imemRequest || mem_pause) begin
      imemReady = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= mem_lat) begin
      imemReady = 1'b1;
      wait_cnt = 0;
    end else begin
      imemReady = 1'b0;
      wait_cnt++;
    end
    imemData = imemReady ? word_at(imemAddress) : 32'hDEAD_BEEF;
  end

  // ---------------- monitor ----------------
  logic        p_rst, p_req, p_rdy, p_stall;
  logic [31:0] p_addr;
  logic [31:0] last_pc4 = '0;
  logic [31:0] last_instr = '0;
  logic        last_valid = 1'b0;
  logic [63:0] e;

  initial forever begin
    @(negedge clock);
    #2;
    p_rst = reset; p_req = imemRequest; p_rdy = imemReady;
    p_stall = shouldStall; p_addr = imemAddress;
    @(posedge clock);
    #1;
    if (!p_rst || !reset) begin
      last_pc4 = '0; last_instr = '0; last_valid = 1'b0;
    end else begin
      if (p_req && p_rdy) begin
        if (exp_addr_q.size() == 0) fail_now("fetch_unexpected");
        else chk("fetch_addr", p_addr, exp_addr_q.pop_front());
      end
      if (p_stall) begin
        chk("stall_hold_valid", {31'd0, instructionValid}, {31'd0, last_valid});
        chk("stall_hold_pc_4", pc_4, last_pc4);
        chk("stall_hold_instr", instruction, last_instr);
      end else if (instructionValid) begin
        if (exp_q.size() == 0) begin
          fail_now("deliver_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pc_4", pc_4, e[63:32]);
          chk("deliver_instr", instruction, e[31:0]);
          last_pc4 = e[63:32]; last_instr = e[31:0]; last_valid = 1'b1;
        end
      end else begin
        chk("bubble_instr", instruction, 32'h0);
        chk("bubble_pc_4", pc_4, last_pc4);
        last_instr = 32'h0; last_valid = 1'b0;
        bubble_cnt++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc(3);
    chk("reset_pc", debug_pc, 32'h0);
    chk("reset_req", {31'd0, imemRequest}, 32'd0);
    chk("reset_valid", {31'd0, instructionValid}, 32'd0);
    chk("reset_pc_4", pc_4, 32'h0);
    chk("reset_instr", instruction, 32'h0);

    // Zero-latency stream, branch at pc 4 targets 0x100 (low bits dropped).
    push_fetch(32'h0); push_fetch(32'h4); push_fetch(32'h8); push_fetch(32'h100);
    push_del(32'h4, 32'h0); push_del(32'h8, 32'h4);
    push_del(32'hC, 32'h8); push_del(32'h104, 32'h100);
    reset = 1'b1;
    cyc(2);
    shouldJumpOrBranch = 1'b1; jumpOrBranchPc = 32'h103;
    cyc(1);
    shouldJumpOrBranch = 1'b0;
    cyc(1);
    mem_pause = 1'b1;
    chk("after_branch_pc", debug_pc, 32'h104);
    cyc(2);

    // Two-cycle latency, branch resolved while the delay slot is in flight.
    push_fetch(32'h104); push_fetch(32'h108); push_fetch(32'h200);
    push_del(32'h108, 32'h104); push_del(32'h10C, 32'h108); push_del(32'h204, 32'h200);
    mem_lat = 2; mem_pause = 1'b0;
    cyc(3);
    shouldJumpOrBranch = 1'b1; jumpOrBranchPc = 32'h200; bubble_cnt = 0;
    cyc(1);
    shouldJumpOrBranch = 1'b0;
    chk("redirect_pc_holds", debug_pc, 32'h108);
    cyc(2);
    chk("bubble_count", bubble_cnt, 32'd2);
    chk("redirect_target", imemAddress, 32'h200);
    cyc(3);
    mem_pause = 1'b1;
    cyc(2);

    // Stall for 3 cycles across a response, then wrap at 0xFFFF_FFFC.
    push_fetch(32'h204); push_fetch(32'h208); push_fetch(32'h20C);
    push_fetch(32'h210); push_fetch(32'hFFFF_FFFC); push_fetch(32'h0); push_fetch(32'h4);
    push_del(32'h208, 32'h204); push_del(32'h20C, 32'h208); push_del(32'h210, 32'h20C);
    push_del(32'h214, 32'h210); push_del(32'h0, 32'hFFFF_FFFC);
    push_del(32'h4, 32'h0); push_del(32'h8, 32'h4);
    mem_lat = 0; mem_pause = 1'b0;
    cyc(1);
    shouldStall = 1'b1;
    cyc(1);
    chk("stall_req_drop", {31'd0, imemRequest}, 32'd0);
    chk("stall_pc_hold", debug_pc, 32'h208);
    cyc(2);
    chk("stall_req_still_low", {31'd0, imemRequest}, 32'd0);
    shouldStall = 1'b0;
    cyc(1);
    chk("resume_req", {31'd0, imemRequest}, 32'd1);
    chk("resume_addr", imemAddress, 32'h20C);
    cyc(1);
    shouldJumpOrBranch = 1'b1; jumpOrBranchPc = 32'hFFFF_FFFC;
    cyc(1);
    shouldJumpOrBranch = 1'b0;
    chk("top_addr", imemAddress, 32'hFFFF_FFFC);
    cyc(1);
    chk("wrap_addr", imemAddress, 32'h0);
    chk("wrap_pc_4", pc_4, 32'h0);
    cyc(1);
    shouldJumpOrBranch = 1'b1; jumpOrBranchPc = 32'h40;
    cyc(1);
    shouldJumpOrBranch = 1'b0; mem_pause = 1'b1;
    cyc(2);
    chk("wait_req", {31'd0, imemRequest}, 32'd1);
    chk("wait_addr", imemAddress, 32'h40);

    // Reset while the fetch at 0x40 is outstanding; a late ready is ignored.
    reset = 1'b0;
    #1;
    chk("midreset_pc", debug_pc, 32'h0);
    chk("midreset_req", {31'd0, imemRequest}, 32'd0);
    chk("midreset_valid", {31'd0, instructionValid}, 32'd0);
    chk("midreset_instr", instruction, 32'h0);
    mem_force = 1'b1;
    cyc(2);
    chk("late_ready_pc", debug_pc, 32'h0);
    chk("late_ready_valid", {31'd0, instructionValid}, 32'd0);
    push_fetch(32'h0);
    push_del(32'h4, 32'h0);
    mem_force = 1'b0; mem_pause = 1'b0; reset = 1'b1;
    cyc(1);
    mem_pause = 1'b1;
    cyc(3);
    chk("post_reset_pc", debug_pc, 32'h4);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("exp_addr_q_drained", exp_addr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
